// File: rtl/hop_table_sequencer.sv
// Frequency-hop table sequencer: plays a programmable table of phase words out as
// CtrlPort writes with a fixed dwell between hops. Optional macro: HOP_SEQ_ONESHOT_EN.
module hop_table_sequencer #(
   parameter int          TABLE_AW      = 4,
   parameter int          PHASE_W       = 32,
   parameter int          DWELL_W       = 24,
   parameter logic [19:0] TARGET_ADDR   = 20'd132,
   parameter logic [9:0]  TARGET_PORTID = 10'd2,
   parameter int          ACK_TIMEOUT   = 64
) (
   input  logic                ctrlport_clk,
   input  logic                ctrlport_rst,
   input  logic                i_tbl_wr_en,
   input  logic [TABLE_AW-1:0] i_tbl_wr_addr,
   input  logic [PHASE_W-1:0]  i_tbl_wr_data,
   input  logic [TABLE_AW:0]   i_cfg_len,
   input  logic [DWELL_W-1:0]  i_cfg_dwell,
   input  logic                i_start,
   input  logic                i_stop,
   output logic                o_req_wr,
   output logic                o_req_rd,
   output logic [19:0]         o_req_addr,
   output logic [9:0]          o_req_portid,
   output logic [31:0]         o_req_data,
   input  logic                i_resp_ack,
   output logic                o_busy,
   output logic [TABLE_AW-1:0] o_hop_index,
   output logic [15:0]         o_hop_count,
   output logic                o_err_timeout,
   output logic                o_err_overrun,
   output logic                o_done
);

   localparam int                DEPTH     = 2**TABLE_AW;
   localparam int                TMO_W     = $clog2(ACK_TIMEOUT);
   localparam logic [TABLE_AW:0] DEPTH_L   = (TABLE_AW+1)'(DEPTH);
   localparam logic [DWELL_W-1:0] DWELL_MIN = DWELL_W'(4);
   localparam logic [TMO_W-1:0]  TMO_LOAD  = TMO_W'(ACK_TIMEOUT-1);

`ifdef HOP_SEQ_ONESHOT_EN
   localparam logic ONESHOT = 1'b1;
`else
   localparam logic ONESHOT = 1'b0;
`endif

   typedef enum logic [1:0] {
      S_IDLE  = 2'd0,
      S_LOAD  = 2'd1,
      S_ISSUE = 2'd2,
      S_WAIT  = 2'd3
   } state_t;

   state_t               r_state;
   state_t               w_state_nxt;
   logic [PHASE_W-1:0]   r_table [DEPTH];
   logic [PHASE_W-1:0]   r_nxt;
   logic [TABLE_AW-1:0]  r_idx;
   logic [TABLE_AW:0]    r_last_idx;
   logic [DWELL_W-1:0]   r_dwell;
   logic [DWELL_W-1:0]   r_period;
   logic [TMO_W-1:0]     r_tmo;
   logic                 r_acked;
   logic                 r_stop_pending;
   logic                 r_last_hop;
   logic                 r_req_wr;
   logic [31:0]          r_req_data;
   logic                 r_busy;
   logic [TABLE_AW-1:0]  r_hop_index;
   logic [15:0]          r_hop_count;
   logic                 r_err_timeout;
   logic                 r_err_overrun;
   logic                 r_done;

   logic                 w_period_zero;
   logic                 w_tmo_zero;
   logic                 w_acked;
   logic                 w_timeout_hit;
   logic                 w_overrun_hit;
   logic                 w_stop_req;
   logic                 w_done;
   logic                 w_start_take;
   logic                 w_issue_next;
   logic [TABLE_AW:0]    w_last_idx_cfg;
   logic [DWELL_W-1:0]   w_dwell_cfg;
   logic [TABLE_AW-1:0]  w_idx_inc;
   logic [PHASE_W-1:0]   w_issue_word;

   assign o_req_wr      = r_req_wr;
   assign o_req_rd      = 1'b0;
   assign o_req_addr    = TARGET_ADDR;
   assign o_req_portid  = TARGET_PORTID;
   assign o_req_data    = r_req_data;
   assign o_busy        = r_busy;
   assign o_hop_index   = r_hop_index;
   assign o_hop_count   = r_hop_count;
   assign o_err_timeout = r_err_timeout;
   assign o_err_overrun = r_err_overrun;
   assign o_done        = r_done;

   assign w_period_zero = (r_period == {DWELL_W{1'b0}});
   assign w_tmo_zero    = (r_tmo == {TMO_W{1'b0}});
   // A hop counts as acked on a real ack or once its ack window has run out
   assign w_acked       = r_acked | i_resp_ack | w_tmo_zero;
   assign w_timeout_hit = (r_state == S_WAIT) & ~r_acked & ~i_resp_ack & w_tmo_zero;
   assign w_stop_req    = r_stop_pending | i_stop;
   assign w_start_take  = (r_state == S_IDLE) & (w_state_nxt == S_LOAD);
   assign w_issue_next  = (w_state_nxt == S_ISSUE);
   assign w_idx_inc     = ({1'b0, r_idx} == r_last_idx) ? {TABLE_AW{1'b0}} : r_idx + TABLE_AW'(1);
   assign w_dwell_cfg   = (i_cfg_dwell < DWELL_MIN) ? DWELL_MIN : i_cfg_dwell;
   // Entry 0 is fetched straight from the table when leaving LOAD
   assign w_issue_word  = (r_state == S_LOAD) ? r_table[r_idx] : r_nxt;

   // Clamp the lap length to 1..DEPTH and keep it as a last index
   always_comb begin
      w_last_idx_cfg = {(TABLE_AW+1){1'b0}};
      if (i_cfg_len == {(TABLE_AW+1){1'b0}}) begin
         w_last_idx_cfg = {(TABLE_AW+1){1'b0}};
      end else if (i_cfg_len > DEPTH_L) begin
         w_last_idx_cfg = DEPTH_L - (TABLE_AW+1)'(1);
      end else begin
         w_last_idx_cfg = i_cfg_len - (TABLE_AW+1)'(1);
      end
   end

   // Next-state and per-cycle event decode
   always_comb begin
      w_state_nxt   = r_state;
      w_done        = 1'b0;
      w_overrun_hit = 1'b0;
      case (r_state)
         S_IDLE: begin
            if (i_start && !i_stop) begin
               w_state_nxt = S_LOAD;
            end else begin
               w_state_nxt = S_IDLE;
            end
         end
         S_LOAD: begin
            if (i_stop) begin
               w_state_nxt = S_IDLE;
            end else begin
               w_state_nxt = S_ISSUE;
            end
         end
         S_ISSUE: begin
            w_state_nxt = S_WAIT;
         end
         S_WAIT: begin
            if (w_period_zero && w_acked) begin
               if (w_stop_req || (ONESHOT && r_last_hop)) begin
                  w_state_nxt = S_IDLE;
                  w_done      = ONESHOT & r_last_hop;
               end else begin
                  w_state_nxt = S_ISSUE;
               end
            end else if (w_period_zero) begin
               w_overrun_hit = 1'b1;
            end else begin
               w_state_nxt = S_WAIT;
            end
         end
         default: begin
            w_state_nxt = S_IDLE;
         end
      endcase
   end

   // Hop table storage, writable in every state
   always_ff @(posedge ctrlport_clk) begin
      if (ctrlport_rst) begin
         for (int i = 0; i < DEPTH; i++) begin
            r_table[i] <= {PHASE_W{1'b0}};
         end
      end else if (i_tbl_wr_en) begin
         r_table[i_tbl_wr_addr] <= i_tbl_wr_data;
      end
   end

   // Sequencer state, counters and registered outputs
   always_ff @(posedge ctrlport_clk) begin
      if (ctrlport_rst) begin
         r_state        <= S_IDLE;
         r_nxt          <= {PHASE_W{1'b0}};
         r_idx          <= {TABLE_AW{1'b0}};
         r_last_idx     <= {(TABLE_AW+1){1'b0}};
         r_dwell        <= DWELL_MIN;
         r_period       <= {DWELL_W{1'b0}};
         r_tmo          <= {TMO_W{1'b0}};
         r_acked        <= 1'b0;
         r_stop_pending <= 1'b0;
         r_last_hop     <= 1'b0;
         r_req_wr       <= 1'b0;
         r_req_data     <= 32'd0;
         r_busy         <= 1'b0;
         r_hop_index    <= {TABLE_AW{1'b0}};
         r_hop_count    <= 16'd0;
         r_err_timeout  <= 1'b0;
         r_err_overrun  <= 1'b0;
         r_done         <= 1'b0;
      end else begin
         r_state  <= w_state_nxt;
         r_busy   <= (w_state_nxt != S_IDLE) || (r_state != S_IDLE);
         r_req_wr <= w_issue_next;
         r_done   <= w_done;

         if (r_state == S_IDLE) begin
            r_stop_pending <= 1'b0;
         end else if (i_stop) begin
            r_stop_pending <= 1'b1;
         end

         if (r_state == S_ISSUE) begin
            r_nxt <= r_table[r_idx];
         end

         if (w_start_take) begin
            r_last_idx    <= w_last_idx_cfg;
            r_dwell       <= w_dwell_cfg;
            r_idx         <= {TABLE_AW{1'b0}};
            r_hop_count   <= 16'd0;
            r_err_timeout <= 1'b0;
            r_err_overrun <= 1'b0;
         end else begin
            if (w_timeout_hit) begin
               r_err_timeout <= 1'b1;
            end
            if (w_overrun_hit) begin
               r_err_overrun <= 1'b1;
            end
         end

         // Dwell and ack window both start on the edge that enters ISSUE
         if (w_issue_next) begin
            r_req_data  <= 32'(w_issue_word);
            r_hop_index <= r_idx;
            r_hop_count <= r_hop_count + 16'd1;
            r_idx       <= w_idx_inc;
            r_last_hop  <= ({1'b0, r_idx} == r_last_idx);
            r_period    <= r_dwell - DWELL_W'(1);
            r_tmo       <= TMO_LOAD;
            r_acked     <= 1'b0;
         end else if ((r_state == S_ISSUE) || (r_state == S_WAIT)) begin
            if (!w_period_zero) begin
               r_period <= r_period - DWELL_W'(1);
            end
            if (!w_tmo_zero) begin
               r_tmo <= r_tmo - TMO_W'(1);
            end
            if ((r_state == S_WAIT) && w_acked) begin
               r_acked <= 1'b1;
            end
         end
      end
   end

endmodule

// File: tb/tb_hop_table_sequencer.sv
// Directed self-checking bench for hop_table_sequencer; expected hop times and
// data are hand-derived from the start cycle of each run.
module tb_hop_table_sequencer;

   localparam logic [31:0] W_A = 32'h1111_000A;
   localparam logic [31:0] W_B = 32'h2222_000B;
   localparam logic [31:0] W_C = 32'h3333_000C;
   localparam logic [31:0] W_D = 32'h4444_000D;
   localparam logic [31:0] W_E = 32'h5555_000E;

   logic        clk;
   logic        rst;
   logic        tbl_wr_en;
   logic [3:0]  tbl_wr_addr;
   logic [31:0] tbl_wr_data;
   logic [4:0]  cfg_len;
   logic [23:0] cfg_dwell;
   logic        start;
   logic        stop;
   logic        req_wr;
   logic        req_rd;
   logic [19:0] req_addr;
   logic [9:0]  req_portid;
   logic [31:0] req_data;
   logic        resp_ack;
   logic        busy;
   logic [3:0]  hop_index;
   logic [15:0] hop_count;
   logic        err_timeout;
   logic        err_overrun;
   logic        done;

   int n_assert = 0;
   int n_fail   = 0;
   int cyc      = 0;
   int ack_dly  = 0;
   int done_cnt = 0;
   int t0;
   int t1;
   int wr_cyc[$];
   logic [31:0] wr_data[$];
   int ack_q[$];

   hop_table_sequencer dut (
      .ctrlport_clk (clk),
      .ctrlport_rst (rst),
      .i_tbl_wr_en  (tbl_wr_en),
      .i_tbl_wr_addr(tbl_wr_addr),
      .i_tbl_wr_data(tbl_wr_data),
      .i_cfg_len    (cfg_len),
      .i_cfg_dwell  (cfg_dwell),
      .i_start      (start),
      .i_stop       (stop),
      .o_req_wr     (req_wr),
      .o_req_rd     (req_rd),
      .o_req_addr   (req_addr),
      .o_req_portid (req_portid),
      .o_req_data   (req_data),
      .i_resp_ack   (resp_ack),
      .o_busy       (busy),
      .o_hop_index  (hop_index),
      .o_hop_count  (hop_count),
      .o_err_timeout(err_timeout),
      .o_err_overrun(err_overrun),
      .o_done       (done)
   );

   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   always @(posedge clk) cyc <= cyc + 1;

   // Record every hop write and schedule its acknowledge
   always @(negedge clk) begin
      if (req_wr) begin
         wr_cyc.push_back(cyc);
         wr_data.push_back(req_data);
         if (ack_dly > 0) ack_q.push_back(cyc + ack_dly);
      end
      if (done) done_cnt = done_cnt + 1;
   end

   initial begin
      resp_ack = 1'b0;
      forever begin
         @(posedge clk);
         #1;
         resp_ack = 1'b0;
         while (ack_q.size() > 0 && ack_q[0] < cyc) void'(ack_q.pop_front());
         if (ack_q.size() > 0 && ack_q[0] == cyc) begin
            void'(ack_q.pop_front());
            resp_ack = 1'b1;
         end
      end
   end

   initial begin
      #400000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1);
   end

   task automatic check_eq(input string tag, input logic [63:0] act, input logic [63:0] exp);
      n_assert = n_assert + 1;
      if (act !== exp) begin
         n_fail = n_fail + 1;
         $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", tag, act, exp, cyc);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic goto_cyc(input int c);
      while (cyc < c) tick();
   endtask

   task automatic tbl_write(input logic [3:0] a, input logic [31:0] d);
      tbl_wr_en = 1'b1; tbl_wr_addr = a; tbl_wr_data = d;
      tick();
      tbl_wr_en = 1'b0;
   endtask

   task automatic start_run(input logic [4:0] len, input logic [23:0] dwell, input int dly);
      wr_cyc.delete(); wr_data.delete(); ack_q.delete();
      ack_dly = dly; cfg_len = len; cfg_dwell = dwell;
      start = 1'b1;
      t0 = cyc;
      tick();
      start = 1'b0;
   endtask

   task automatic pulse_stop();
      stop = 1'b1;
      tick();
      stop = 1'b0;
   endtask

   task automatic wait_idle(input string tag, input int limit);
      int n = 0;
      while (busy && n < limit) begin
         tick();
         n++;
      end
      check_eq(tag, busy, 1'b0);
   endtask

   initial begin
      rst = 1'b1; tbl_wr_en = 1'b0; tbl_wr_addr = 4'd0; tbl_wr_data = 32'd0;
      cfg_len = 5'd0; cfg_dwell = 24'd0; start = 1'b0; stop = 1'b0;
      tick(); tick();
      rst = 1'b0;
      tick();

      check_eq("rst_req_wr",   req_wr, 1'b0);
      check_eq("rst_req_rd",   req_rd, 1'b0);
      check_eq("rst_addr",     req_addr, 20'd132);
      check_eq("rst_portid",   req_portid, 10'd2);
      check_eq("rst_data",     req_data, 32'd0);
      check_eq("rst_busy",     busy, 1'b0);
      check_eq("rst_count",    hop_count, 16'd0);
      check_eq("rst_errs",     {err_timeout, err_overrun, done}, 3'b000);
      check_eq("rst_index",    hop_index, 4'd0);

      tbl_write(4'd0, W_A);
      tbl_write(4'd1, W_B);
      tbl_write(4'd2, W_C);

`ifndef HOP_SEQ_ONESHOT_EN
      // Basic loop: len 3, dwell 10, ack one cycle after each write
      start_run(5'd3, 24'd10, 1);
      goto_cyc(t0 + 33);
      check_eq("basic_nwr", wr_cyc.size(), 4);
      for (int i = 0; i < 4; i++) begin
         if (i < wr_cyc.size()) begin
            check_eq($sformatf("basic_t%0d", i), wr_cyc[i], t0 + 2 + 10 * i);
            check_eq($sformatf("basic_d%0d", i), wr_data[i], (i == 1) ? W_B : (i == 2) ? W_C : W_A);
         end
      end
      check_eq("basic_count", hop_count, 16'd4);
      check_eq("basic_index", hop_index, 4'd0);
      check_eq("basic_errs",  {err_timeout, err_overrun}, 2'b00);
      check_eq("basic_busy",  busy, 1'b1);
      pulse_stop();
      wait_idle("basic_idle", 50);
      check_eq("loop_done", done_cnt, 0);

      // Stop three cycles after the second write
      start_run(5'd3, 24'd10, 1);
      goto_cyc(t0 + 15);
      pulse_stop();
      goto_cyc(t0 + 22);
      check_eq("stop_busy_hi", busy, 1'b1);
      tick();
      check_eq("stop_busy_lo", busy, 1'b0);
      goto_cyc(t0 + 45);
      check_eq("stop_nwr", wr_cyc.size(), 2);
      start_run(5'd3, 24'd10, 1);
      t1 = t0;
      check_eq("restart_count0", hop_count, 16'd0);
      check_eq("restart_busy", busy, 1'b1);
      tick();
      check_eq("restart_wr", req_wr, 1'b1);
      check_eq("restart_data", req_data, W_A);
      check_eq("restart_count1", hop_count, 16'd1);
      pulse_stop();
      wait_idle("restart_idle", 50);

      // Ack never arrives: timeout at 64, writes still 100 apart
      start_run(5'd1, 24'd100, 0);
      goto_cyc(t0 + 2 + 63);
      check_eq("tmo_pre", err_timeout, 1'b0);
      tick();
      check_eq("tmo_set", err_timeout, 1'b1);
      goto_cyc(t0 + 2 + 101);
      check_eq("tmo_nwr", wr_cyc.size(), 2);
      if (wr_cyc.size() >= 2) check_eq("tmo_gap", wr_cyc[1] - wr_cyc[0], 100);
      check_eq("tmo_no_ovr", err_overrun, 1'b0);
      pulse_stop();
      wait_idle("tmo_idle", 250);

      // Ack 15 cycles late with dwell 10: overrun, 16-cycle spacing
      start_run(5'd1, 24'd10, 15);
      goto_cyc(t0 + 2 + 9);
      check_eq("ovr_pre", err_overrun, 1'b0);
      tick();
      check_eq("ovr_set", err_overrun, 1'b1);
      goto_cyc(t0 + 2 + 33);
      check_eq("ovr_nwr", wr_cyc.size(), 3);
      if (wr_cyc.size() >= 3) begin
         check_eq("ovr_gap1", wr_cyc[1] - wr_cyc[0], 16);
         check_eq("ovr_gap2", wr_cyc[2] - wr_cyc[1], 16);
      end
      check_eq("ovr_no_tmo", err_timeout, 1'b0);
      pulse_stop();
      wait_idle("ovr_idle", 60);

      // Clamps: len 0 -> 1, dwell 1 -> 4; then reset mid-WAIT
      tbl_write(4'd0, W_D);
      tbl_write(4'd1, W_E);
      start_run(5'd0, 24'd1, 1);
      goto_cyc(t0 + 11);
      check_eq("clamp_nwr", wr_cyc.size(), 3);
      if (wr_cyc.size() >= 3) begin
         check_eq("clamp_t0", wr_cyc[0], t0 + 2);
         check_eq("clamp_gap1", wr_cyc[1] - wr_cyc[0], 4);
         check_eq("clamp_gap2", wr_cyc[2] - wr_cyc[1], 4);
         check_eq("clamp_d1", wr_data[1], W_D);
         check_eq("clamp_d2", wr_data[2], W_D);
      end
      check_eq("clamp_index", hop_index, 4'd0);
      rst = 1'b1;
      tick();
      rst = 1'b0;
      check_eq("mid_rst_wr",    req_wr, 1'b0);
      check_eq("mid_rst_busy",  busy, 1'b0);
      check_eq("mid_rst_count", hop_count, 16'd0);
      check_eq("mid_rst_data",  req_data, 32'd0);
      goto_cyc(t0 + 40);
      check_eq("mid_rst_nwr", wr_cyc.size(), 3);
`else
      // Oneshot: len 2, dwell 8 -> two writes then a single done pulse
      start_run(5'd2, 24'd8, 1);
      goto_cyc(t0 + 17);
      check_eq("os_done_pre", done, 1'b0);
      tick();
      check_eq("os_done", done, 1'b1);
      tick();
      check_eq("os_done_post", done, 1'b0);
      check_eq("os_busy", busy, 1'b0);
      goto_cyc(t0 + 40);
      check_eq("os_nwr", wr_cyc.size(), 2);
      if (wr_cyc.size() >= 2) begin
         check_eq("os_t1", wr_cyc[1], t0 + 10);
         check_eq("os_d1", wr_data[1], W_B);
      end
      check_eq("os_done_cnt", done_cnt, 1);
`endif

      $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
      $finish;
   end

endmodule
